// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: serial signed dot-product with bias, optional ReLU, valid/ready result
module neuron_mac_sequencer #(
  parameter int INP_WIDTH = 8,
  parameter int N_INPUTS = 4,
  parameter int ACC_WIDTH = 24,
  parameter bit RELU_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic signed [ACC_WIDTH-1:0] bias,
  input  logic in_valid,
  output logic in_ready,
  input  logic signed [INP_WIDTH-1:0] x,
  input  logic signed [INP_WIDTH-1:0] w,
  output logic out_valid,
  input  logic out_ready,
  output logic signed [ACC_WIDTH-1:0] y,
  output logic busy,
  output logic ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic signed [ACC_WIDTH-1:0] acc, prod_x, sum;
  logic signed [2*INP_WIDTH-1:0] prod;
  logic accept, last, sum_ovf;
  assign prod = x * w;
  assign prod_x = ACC_WIDTH'(prod);
  assign sum = acc + prod_x;
  assign sum_ovf = (acc[ACC_WIDTH-1] == prod_x[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  assign in_ready = state == RUN;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign accept = in_valid && in_ready;
  assign last = cnt == CW'(N_INPUTS - 1);
  always_comb begin
    state_nx = abort ? IDLE :
               (state == IDLE && start) ? RUN :
               (state == RUN && accept && last) ? DONE :
               (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      y <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (abort) begin
        cnt <= '0;
      end else if (state == IDLE && start) begin
        acc <= bias;
        cnt <= '0;
        ovf <= 1'b0;
      end else if (accept) begin
        acc <= sum;
        cnt <= cnt + 1'b1;
        ovf <= ovf | sum_ovf;
        if (last) y <= (RELU_EN && sum[ACC_WIDTH-1]) ? '0 : sum;
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb_neuron_mac_sequencer: directed checks of three sequencer variants driven in lockstep
module tb_neuron_mac_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, abort, in_valid, out_ready;
  logic [23:0] bias;
  logic [7:0] x, w;
  logic ir_r, ov_r, bz_r, of_r, ir_l, ov_l, bz_l, of_l, ir_s, ov_s, bz_s, of_s;
  logic [23:0] y_r, y_l;
  logic [15:0] y_s;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  neuron_mac_sequencer d_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias),
    .in_valid(in_valid), .in_ready(ir_r), .x(x), .w(w), .out_valid(ov_r),
    .out_ready(out_ready), .y(y_r), .busy(bz_r), .ovf(of_r)
  );
  neuron_mac_sequencer #(.RELU_EN(1'b0)) d_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias),
    .in_valid(in_valid), .in_ready(ir_l), .x(x), .w(w), .out_valid(ov_l),
    .out_ready(out_ready), .y(y_l), .busy(bz_l), .ovf(of_l)
  );
  neuron_mac_sequencer #(.ACC_WIDTH(16), .RELU_EN(1'b0)) d_16 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bias(bias[15:0]),
    .in_valid(in_valid), .in_ready(ir_s), .x(x), .w(w), .out_valid(ov_s),
    .out_ready(out_ready), .y(y_s), .busy(bz_s), .ovf(of_s)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_start(input int b);
    start = 1'b1;
    bias = 24'(b);
    tick();
    start = 1'b0;
  endtask
  task automatic feed(input int xv, input int wv, input int gap);
    in_valid = 1'b1;
    x = 8'(xv);
    w = 8'(wv);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      chk("gap_in_ready", {31'b0, ir_l}, 1);
      chk("gap_out_valid", {31'b0, ov_l}, 0);
      tick();
    end
  endtask
  task automatic feed_t1(input int gap);
    feed(3, 4, gap);
    feed(-2, 5, gap);
    feed(7, -1, gap);
    feed(-8, -8, 0);
  endtask
  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias = '0; x = '0; w = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", {31'b0, ir_l}, 0);
    chk("rst_out_valid", {31'b0, ov_l}, 0);
    chk("rst_busy", {31'b0, bz_l}, 0);
    chk("rst_ovf", {31'b0, of_l}, 0);
    chk("rst_y", {8'b0, y_l}, 0);
    // test 1
    do_start(10);
    chk("t1_busy", {31'b0, bz_l}, 1);
    chk("t1_in_ready", {31'b0, ir_l}, 1);
    feed(3, 4, 0);
    feed(-2, 5, 0);
    feed(7, -1, 0);
    chk("t1_no_early_valid", {31'b0, ov_l}, 0);
    feed(-8, -8, 0);
    chk("t1_out_valid", {31'b0, ov_l}, 1);
    chk("t1_in_ready_done", {31'b0, ir_l}, 0);
    chk("t1_y", {8'b0, y_l}, 69);
    chk("t1_ovf", {31'b0, of_l}, 0);
    handshake();
    chk("t1_idle_busy", {31'b0, bz_l}, 0);
    chk("t1_idle_valid", {31'b0, ov_l}, 0);
    // test 2
    do_start(-100);
    for (int i = 0; i < 4; i++) feed(1, 1, 0);
    chk("t2_relu_y", {8'b0, y_r}, 0);
    chk("t2_lin_y", {8'b0, y_l}, 32'h00FFFFA0);
    handshake();
    // test 3
    do_start(10);
    feed_t1(2);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_valid", {31'b0, ov_l}, 1);
      chk("t3_hold_y", {8'b0, y_l}, 69);
      tick();
    end
    handshake();
    chk("t3_busy", {31'b0, bz_l}, 0);
    chk("t3_y_hold", {8'b0, y_l}, 69);
    // test 4
    do_start(0);
    for (int i = 0; i < 4; i++) feed(-128, -128, 0);
    chk("t4_y24", {8'b0, y_l}, 65536);
    chk("t4_ovf24", {31'b0, of_l}, 0);
    chk("t4_y24_relu", {8'b0, y_r}, 65536);
    chk("t4_y16", {16'b0, y_s}, 0);
    chk("t4_ovf16", {31'b0, of_s}, 1);
    handshake();
    chk("t4_ovf16_sticky", {31'b0, of_s}, 1);
    do_start(0);
    chk("t4_ovf16_cleared", {31'b0, of_s}, 0);
    // test 5: abort after 2nd accept of the op just started
    feed(3, 4, 0);
    feed(-2, 5, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_abort_in_ready", {31'b0, ir_l}, 0);
    chk("t5_abort_busy", {31'b0, bz_l}, 0);
    chk("t5_abort_valid", {31'b0, ov_l}, 0);
    tick();
    chk("t5_abort_stays_idle", {31'b0, ov_l | bz_l}, 0);
    do_start(10);
    feed(3, 4, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_in_ready", {31'b0, ir_l}, 0);
    chk("t5_rst_busy", {31'b0, bz_l}, 0);
    chk("t5_rst_y", {8'b0, y_l}, 0);
    chk("t5_rst_y_relu", {8'b0, y_r}, 0);
    do_start(10);
    feed_t1(0);
    chk("t5_restart_y", {8'b0, y_l}, 69);
    handshake();
    // test 6
    do_start(10);
    feed(3, 4, 0);
    start = 1'b1;
    bias = 24'd500;
    tick();
    start = 1'b0;
    feed(-2, 5, 0);
    feed(7, -1, 0);
    feed(-8, -8, 0);
    chk("t6_run_start_ignored", {8'b0, y_l}, 69);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_done_start_valid", {31'b0, ov_l}, 1);
    chk("t6_done_start_y", {8'b0, y_l}, 69);
    handshake();
    do_start(-100);
    chk("t6_b2b_busy", {31'b0, bz_l}, 1);
    for (int i = 0; i < 4; i++) feed(1, 1, 0);
    chk("t6_b2b_y", {8'b0, y_l}, 32'h00FFFFA0);
    chk("t6_b2b_relu_y", {8'b0, y_r}, 0);
    handshake();
    chk("t6_final_busy", {31'b0, bz_l}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
